renkon_serial_buf: RTL and testbench
====================================

# renkon_serial_buf

Output serializer between the renkon convolution cores and the image-memory write port driven by `renkon_ctrl_core`. On each write strobe it captures all cores' result pixels in parallel into a per-core buffer. On each read strobe it returns one selected core's pixel as the single `out_wdata` stream that `renkon_ctrl_core` writes back to image memory. Buffer addressing and core selection come entirely from `renkon_ctrl_core` (`serial_we`, `serial_re`, `serial_addr`).

## Interface
Parameters:
- `RENKON_CORE`, 8, number of parallel cores / buffer banks
- `RENKON_CORELOG`, 3, log2(`RENKON_CORE`)
- `DWIDTH`, 16, signed pixel width
- `OUTSIZE`, 10, buffer address width; depth per bank is 2^`OUTSIZE`

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all logic on rising edge
- `xrst`  in  1  synchronous active-low reset
- `serial_we`  in  1  capture strobe for all banks at `serial_addr`
- `in_data`  in  `RENKON_CORE*DWIDTH`  packed signed core outputs; core k at bits [k*DWIDTH +: DWIDTH]
- `serial_re`  in  `RENKON_CORELOG+1`  read select; 0 = idle, k (1..`RENKON_CORE`) = read bank k-1
- `serial_addr`  in  `OUTSIZE`  shared read/write address
- `out_wdata`  out  `DWIDTH`  signed serialized pixel
- `out_valid`  out  1  `out_wdata` holds a freshly read pixel
- `err`  out  1  sticky: illegal `serial_re` (> `RENKON_CORE`) seen

## Operation
- Storage: `RENKON_CORE` banks, each 2^`OUTSIZE` x `DWIDTH`. Contents are not reset and are undefined until written.
- Write: `serial_we`=1 stores `in_data` slice k into bank k at `serial_addr` for every k in the same cycle.
- Read: `serial_re`=k in 1..`RENKON_CORE` reads bank k-1 at `serial_addr`. The result is registered into `out_wdata`, and `out_valid` is set for one cycle.
- Idle: `serial_re`=0 holds `out_wdata` at its last value and clears `out_valid`.
- Illegal select: `serial_re` > `RENKON_CORE` is treated as idle and sets `err`. `err` clears only on reset.
- Simultaneous write and read at the same address is read-before-write: the read returns the old contents, and the new data is visible from the next cycle.
- Write and read are independent and may occur every cycle. There is no back-pressure.
- No address wrap logic. `serial_addr` is used directly, and the full 2^`OUTSIZE` range is legal.

## Timing
- Reset (`xrst`=0 at a rising edge): `out_wdata`=0, `out_valid`=0, `err`=0. The buffer is untouched.
- Read latency is 1 cycle: `serial_re` asserted in cycle n gives `out_wdata`/`out_valid` valid after edge n+1. This matches `renkon_ctrl_core`, which delays `img_we` one cycle behind `serial_re`.
- Write takes effect at the edge where `serial_we` is sampled.
- Reset mid-stream: any pending read is discarded (`out_valid`=0 the following cycle). Writes in the reset cycle are ignored.
- Back-to-back reads with different k each produce one valid pixel per cycle, in order.

## Configuration
- `RENKON_SERIAL_RELU_EN` defined: the read path applies ReLU. A negative stored value yields `out_wdata`=0; a non-negative value passes unchanged. Latency is unchanged.
- Not defined: stored values are output unmodified, sign included.

## Test plan
- Reset: hold `xrst`=0 for 2 cycles with `serial_re`=3 -> `out_wdata`=0, `out_valid`=0, `err`=0 throughout.
- Parallel write/serial read:
  - Stimulus: write `in_data` core k = 100+k at addr 5; then `serial_re`=1..8 on consecutive cycles at addr 5.
  - Response: `out_wdata`=100..107, one per cycle, starting 1 cycle after the first read; `out_valid` high for 8 cycles.
- Collision:
  - Stimulus: addr 7 holds core0 = 11; same cycle `serial_we`=1 with core0 = 22 and `serial_re`=1 at addr 7.
  - Response: `out_wdata`=11; a read at addr 7 next cycle returns 22.
- Address boundary: write at addr 0 and at addr 1023 with distinct values -> both read back exactly, no aliasing.
- Illegal select: `serial_re`=9 -> `out_valid`=0, `out_wdata` unchanged, `err`=1 and stays 1 until reset.
- Sign handling: store -5 in core2 and read with `serial_re`=3 -> `out_wdata`=-5 without `RENKON_SERIAL_RELU_EN`, 0 with it.

Source files
------------

// File: rtl/renkon_serial_buf.sv
// renkon_serial_buf: parallel-capture, one-bank-per-read output serializer.
// Define RENKON_SERIAL_RELU_EN to clamp negative pixels to zero on the read path.
module renkon_serial_buf #(
    parameter int RENKON_CORE    = 8,
    parameter int RENKON_CORELOG = 3,
    parameter int DWIDTH         = 16,
    parameter int OUTSIZE        = 10
) (
    input  logic                             clk,
    input  logic                             xrst,
    input  logic                             serial_we,
    input  logic [RENKON_CORE*DWIDTH-1:0]    in_data,
    input  logic [RENKON_CORELOG:0]          serial_re,
    input  logic [OUTSIZE-1:0]               serial_addr,
    output logic signed [DWIDTH-1:0]         out_wdata,
    output logic                             out_valid,
    output logic                             err
);
    localparam logic [RENKON_CORELOG:0] NCORE = (RENKON_CORELOG+1)'(RENKON_CORE);
    localparam logic [RENKON_CORELOG:0] ONE   = (RENKON_CORELOG+1)'(1);

    logic [DWIDTH-1:0] mem_q [RENKON_CORE][2**OUTSIZE];
    logic                     rd_en;
    logic                     bad_sel;
    logic [RENKON_CORELOG:0]  bank;
    logic [DWIDTH-1:0]        rd_raw;
    logic signed [DWIDTH-1:0] out_wdata_d, out_wdata_q;
    logic                     out_valid_d, out_valid_q;
    logic                     err_d, err_q;

    // Buffer contents are deliberately not reset; writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (xrst && serial_we)
            for (int k = 0; k < RENKON_CORE; k++)
                mem_q[k][serial_addr] <= in_data[k*DWIDTH +: DWIDTH];
    end

    always_comb begin
        rd_en   = (serial_re != '0) && (serial_re <= NCORE);
        bad_sel = serial_re > NCORE;
        bank    = serial_re - ONE;
        rd_raw  = mem_q[bank[RENKON_CORELOG-1:0]][serial_addr];
`ifdef RENKON_SERIAL_RELU_EN
        out_wdata_d = rd_en ? (rd_raw[DWIDTH-1] ? '0 : $signed(rd_raw)) : out_wdata_q;
`else
        out_wdata_d = rd_en ? $signed(rd_raw) : out_wdata_q;
`endif
        out_valid_d = rd_en;
        err_d       = err_q | bad_sel;
    end

    // Reading through the registered port before the write lands gives read-before-write.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            out_wdata_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_wdata_q <= out_wdata_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_wdata = out_wdata_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_renkon_serial_buf.sv
// tb_renkon_serial_buf: directed and random checks of renkon_serial_buf against a bank-array model.
module tb_renkon_serial_buf;
    localparam int N  = 8;
    localparam int LG = 3;
    localparam int W  = 16;
    localparam int AW = 10;

    logic                 clk = 1'b0;
    logic                 xrst = 1'b0;
    logic                 serial_we = 1'b0;
    logic [N*W-1:0]       in_data = '0;
    logic [LG:0]          serial_re = '0;
    logic [AW-1:0]        serial_addr = '0;
    logic signed [W-1:0]  out_wdata;
    logic                 out_valid;
    logic                 err;

    renkon_serial_buf #(.RENKON_CORE(N), .RENKON_CORELOG(LG), .DWIDTH(W), .OUTSIZE(AW)) dut (
        .clk(clk), .xrst(xrst), .serial_we(serial_we), .in_data(in_data),
        .serial_re(serial_re), .serial_addr(serial_addr),
        .out_wdata(out_wdata), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mdl [N][1<<AW];
    int exp_out = 0;
    int exp_valid = 0;
    int exp_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef RENKON_SERIAL_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [N*W-1:0] pack(input int base);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(base + k);
        return d;
    endfunction

    task automatic step(input bit rst_n, input bit we, input int re, input int addr, input logic [N*W-1:0] d);
        xrst = rst_n;
        serial_we = we;
        serial_re = re[LG:0];
        serial_addr = addr[AW-1:0];
        in_data = d;
        @(posedge clk);
        if (!rst_n) begin
            exp_out = 0;
            exp_valid = 0;
            exp_err = 0;
        end else begin
            exp_valid = (re >= 1 && re <= N) ? 1 : 0;
            if (exp_valid == 1) exp_out = relu(mdl[re-1][addr]);
            if (re > N) exp_err = 1;
            if (we) for (int k = 0; k < N; k++) mdl[k][addr] = int'($signed(d[k*W +: W]));
        end
        @(negedge clk);
        chk("valid", {31'b0, out_valid}, exp_valid);
        chk("err", {31'b0, err}, exp_err);
        chk("wdata", 32'(out_wdata), exp_out);
    endtask

    initial begin
        logic [N*W-1:0] d;
        @(negedge clk);
        step(0, 0, 3, 0, '0);
        step(0, 0, 3, 0, '0);
        chk("rst_wdata", 32'(out_wdata), 0);
        chk("rst_valid", {31'b0, out_valid}, 0);

        step(1, 1, 0, 5, pack(100));
        for (int k = 1; k <= N; k++) begin
            step(1, 0, k, 5, '0);
            chk("par_read", 32'(out_wdata), 99 + k);
            chk("par_valid", {31'b0, out_valid}, 1);
        end
        step(1, 0, 0, 5, '0);
        chk("idle_hold", 32'(out_wdata), 107);
        chk("idle_valid", {31'b0, out_valid}, 0);

        step(1, 1, 0, 7, pack(11));
        step(1, 1, 1, 7, pack(22));
        chk("collide_old", 32'(out_wdata), 11);
        step(1, 0, 1, 7, '0);
        chk("collide_new", 32'(out_wdata), 22);

        step(1, 1, 0, 0, pack(300));
        step(1, 1, 0, 1023, pack(500));
        step(1, 0, 4, 0, '0);
        chk("addr0", 32'(out_wdata), 303);
        step(1, 0, 8, 1023, '0);
        chk("addr1023", 32'(out_wdata), 507);

        d = pack(40);
        d[2*W +: W] = W'(-5);
        step(1, 1, 0, 9, d);
        step(1, 0, 3, 9, '0);
`ifdef RENKON_SERIAL_RELU_EN
        chk("sign", 32'(out_wdata), 0);
`else
        chk("sign", 32'(out_wdata), -5);
`endif
        step(1, 0, 2, 9, '0);
        chk("sign_pos", 32'(out_wdata), 41);

        step(1, 0, 9, 5, '0);
        chk("bad_valid", {31'b0, out_valid}, 0);
        chk("bad_hold", 32'(out_wdata), 41);
        chk("bad_err", {31'b0, err}, 1);
        for (int i = 0; i < 3; i++) step(1, 0, i, 5, '0);
        chk("err_sticky", {31'b0, err}, 1);
        step(0, 1, 0, 5, pack(900));
        chk("err_reset", {31'b0, err}, 0);
        step(1, 0, 1, 5, '0);
        chk("rst_write_ignored", 32'(out_wdata), 100);

        for (int a = 0; a < 16; a++) step(1, 1, 0, a, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 10),
                 $urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
